superscalar_issue_splitter: RTL and testbench

Splits each decoded program instruction, which carries a repeat count of up to 255 copies, into superscalar groups of at most 16 copies. Pushes the groups one at a time into the instruction queue's push port. Sits between the instruction decoder and the instruction queue. It honours the queue's `stall_push` back-pressure and advances each group's base cache and main-memory addresses by 16 strides per group.

---
 rtl/superscalar_issue_splitter.sv | 127 ++++++++++++
 tb/tb_superscalar_issue_splitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/superscalar_issue_splitter.sv
// Splits a repeated decoded instruction into pushes of at most GROUP_WIDTH copies; first push one cycle after accept.
// Back-pressure: stall_push holds every register and masks we; in_ready is low for the whole ISSUE phase.
module superscalar_issue_splitter #(
  parameter int GROUP_WIDTH = 16,
  parameter int REPEAT_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_instr_type,
  input  logic [REPEAT_BITS-1:0]       in_repeat,
  input  logic [10:0]                  in_cache_addr,
  input  logic [10:0]                  in_d_cache_addr,
  input  logic [6:0]                   in_main_mem_addr,
  input  logic [6:0]                   in_d_main_mem_addr,
  input  logic [0:8]                   in_arith_instr,
  input  logic [0:2]                   in_ram_instr,
  input  logic [0:6]                   in_ld_st_instr,
  output logic                         we,
  output logic [1:0]                   instr_type,
  output logic [$clog2(GROUP_WIDTH):0] copy_count,
  output logic [10:0]                  cache_addr,
  output logic [10:0]                  d_cache_addr,
  output logic [6:0]                   main_mem_addr,
  output logic [6:0]                   d_main_mem_addr,
  output logic [0:8]                   arith_instr,
  output logic [0:2]                   ram_instr,
  output logic [0:6]                   ld_st_instr,
  input  logic                         stall_push,
  output logic                         busy
);

  localparam int CNT_BITS = $clog2(GROUP_WIDTH) + 1;
  localparam int SHIFT    = $clog2(GROUP_WIDTH);
  localparam logic [1:0] PROG_END = 2'd3;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [1:0]  instr_type;
    logic [10:0] cache_addr;
    logic [10:0] d_cache_addr;
    logic [6:0]  main_mem_addr;
    logic [6:0]  d_main_mem_addr;
    logic [0:8]  arith_instr;
    logic [0:2]  ram_instr;
    logic [0:6]  ld_st_instr;
  } instr_t;

  state_t                 state;
  logic                   busy_q;
  instr_t                 cur;
  logic [REPEAT_BITS-1:0] remaining;
  logic [REPEAT_BITS-1:0] rem_init;
  logic [REPEAT_BITS-1:0] rem_next;
  logic [CNT_BITS-1:0]    copy_count_q;

  function automatic logic [CNT_BITS-1:0] group_of(input logic [REPEAT_BITS-1:0] r);
    if (int'(r) > GROUP_WIDTH) return CNT_BITS'(GROUP_WIDTH);
    else                       return CNT_BITS'(r);
  endfunction

  // A zero repeat still issues one copy; PROG_END never repeats.
  always_comb begin
    rem_init = (in_repeat == '0) ? REPEAT_BITS'(1) : in_repeat;
    if (in_instr_type == PROG_END) rem_init = REPEAT_BITS'(1);
  end

  assign rem_next = remaining - REPEAT_BITS'(copy_count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      remaining    <= '0;
      copy_count_q <= '0;
      cur          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur <= '{instr_type:      in_instr_type,
                     cache_addr:      in_cache_addr,
                     d_cache_addr:    in_d_cache_addr,
                     main_mem_addr:   in_main_mem_addr,
                     d_main_mem_addr: in_d_main_mem_addr,
                     arith_instr:     in_arith_instr,
                     ram_instr:       in_ram_instr,
                     ld_st_instr:     in_ld_st_instr};
            remaining    <= rem_init;
            copy_count_q <= group_of(rem_init);
            state        <= ISSUE;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall_push) begin
            remaining         <= rem_next;
            copy_count_q      <= group_of(rem_next);
            // Each group spans GROUP_WIDTH strides; wrap is plain modular.
            cur.cache_addr    <= cur.cache_addr + (cur.d_cache_addr << SHIFT);
            cur.main_mem_addr <= cur.main_mem_addr + (cur.d_main_mem_addr << SHIFT);
            if (rem_next == '0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign in_ready        = !busy_q;
  assign busy            = busy_q;
  assign we              = busy_q && !stall_push;
  assign copy_count      = copy_count_q;
  assign instr_type      = cur.instr_type;
  assign cache_addr      = cur.cache_addr;
  assign d_cache_addr    = cur.d_cache_addr;
  assign main_mem_addr   = cur.main_mem_addr;
  assign d_main_mem_addr = cur.d_main_mem_addr;
  assign arith_instr     = cur.arith_instr;
  assign ram_instr       = cur.ram_instr;
  assign ld_st_instr     = cur.ld_st_instr;

endmodule

// File: tb/tb_superscalar_issue_splitter.sv
// Directed bench for superscalar_issue_splitter with hand-computed expectations.
module tb_superscalar_issue_splitter;

  localparam logic [1:0] T_RAM = 2'd0, T_LDST = 2'd1, T_ARITH = 2'd2, T_END = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_instr_type;
  logic [7:0]  in_repeat;
  logic [10:0] in_cache_addr, in_d_cache_addr;
  logic [6:0]  in_main_mem_addr, in_d_main_mem_addr;
  logic [0:8]  in_arith_instr;
  logic [0:2]  in_ram_instr;
  logic [0:6]  in_ld_st_instr;
  logic        we;
  logic [1:0]  instr_type;
  logic [4:0]  copy_count;
  logic [10:0] cache_addr, d_cache_addr;
  logic [6:0]  main_mem_addr, d_main_mem_addr;
  logic [0:8]  arith_instr;
  logic [0:2]  ram_instr;
  logic [0:6]  ld_st_instr;
  logic        stall_push;
  logic        busy;

  int total = 0;
  int bad   = 0;

  superscalar_issue_splitter #(.GROUP_WIDTH(16), .REPEAT_BITS(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr_type(in_instr_type), .in_repeat(in_repeat),
    .in_cache_addr(in_cache_addr), .in_d_cache_addr(in_d_cache_addr),
    .in_main_mem_addr(in_main_mem_addr), .in_d_main_mem_addr(in_d_main_mem_addr),
    .in_arith_instr(in_arith_instr), .in_ram_instr(in_ram_instr), .in_ld_st_instr(in_ld_st_instr),
    .we(we), .instr_type(instr_type), .copy_count(copy_count),
    .cache_addr(cache_addr), .d_cache_addr(d_cache_addr),
    .main_mem_addr(main_mem_addr), .d_main_mem_addr(d_main_mem_addr),
    .arith_instr(arith_instr), .ram_instr(ram_instr), .ld_st_instr(ld_st_instr),
    .stall_push(stall_push), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Moves to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [1:0] t, input logic [7:0] rep,
                           input logic [10:0] ca, input logic [10:0] dca,
                           input logic [6:0] mm, input logic [6:0] dmm);
    in_instr_type      = t;
    in_repeat          = rep;
    in_cache_addr      = ca;
    in_d_cache_addr    = dca;
    in_main_mem_addr   = mm;
    in_d_main_mem_addr = dmm;
  endtask

  // Presents one instruction for exactly one accepting edge; returns in cycle 1.
  task automatic offer(input string tag);
    chk({tag, "_ready_before"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall_push = 1'b0;
    set_instr(T_RAM, 8'd0, 11'd0, 11'd0, 7'd0, 7'd0);
    in_arith_instr = '0; in_ram_instr = '0; in_ld_st_instr = '0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cc", 32'(copy_count), 0);
    chk("rst_cache", 32'(cache_addr), 0);
    chk("rst_mm", 32'(main_mem_addr), 0);
    chk("rst_type", 32'(instr_type), 0);

    // Repeat 40 arithmetic: 16, 16, 8
    set_instr(T_ARITH, 8'd40, 11'd100, 11'd1, 7'd3, 7'd2);
    in_arith_instr = 9'h1A5;
    offer("t1");
    chk("t1_c1_we", 32'(we), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    chk("t1_c1_ready", 32'(in_ready), 0);
    chk("t1_c1_cc", 32'(copy_count), 16);
    chk("t1_c1_cache", 32'(cache_addr), 100);
    chk("t1_c1_mm", 32'(main_mem_addr), 3);
    chk("t1_c1_arith", 32'(arith_instr), 32'h1A5);
    chk("t1_c1_type", 32'(instr_type), 32'(T_ARITH));
    step();
    chk("t1_c2_we", 32'(we), 1);
    chk("t1_c2_cc", 32'(copy_count), 16);
    chk("t1_c2_cache", 32'(cache_addr), 116);
    chk("t1_c2_mm", 32'(main_mem_addr), 35);
    step();
    chk("t1_c3_we", 32'(we), 1);
    chk("t1_c3_cc", 32'(copy_count), 8);
    chk("t1_c3_cache", 32'(cache_addr), 132);
    chk("t1_c3_mm", 32'(main_mem_addr), 67);
    chk("t1_c3_dmm", 32'(d_main_mem_addr), 2);
    step();
    chk("t1_c4_ready", 32'(in_ready), 1);
    chk("t1_c4_we", 32'(we), 0);
    chk("t1_c4_busy", 32'(busy), 0);

    // Load/store with cache address wrap: 2000, 32, 112
    set_instr(T_LDST, 8'd48, 11'd2000, 11'd5, 7'd0, 7'd0);
    in_ld_st_instr = 7'h55;
    offer("t2");
    chk("t2_c1_we", 32'(we), 1);
    chk("t2_c1_cache", 32'(cache_addr), 2000);
    chk("t2_c1_dca", 32'(d_cache_addr), 5);
    chk("t2_c1_ldst", 32'(ld_st_instr), 32'h55);
    step();
    chk("t2_c2_we", 32'(we), 1);
    chk("t2_c2_cache", 32'(cache_addr), 32);
    chk("t2_c2_dca", 32'(d_cache_addr), 5);
    step();
    chk("t2_c3_we", 32'(we), 1);
    chk("t2_c3_cache", 32'(cache_addr), 112);
    chk("t2_c3_cc", 32'(copy_count), 16);
    step();
    chk("t2_c4_ready", 32'(in_ready), 1);
    chk("t2_c4_we", 32'(we), 0);

    // RAM repeat 20 with stall during cycles 1-3
    set_instr(T_RAM, 8'd20, 11'd0, 11'd0, 7'd10, 7'd3);
    in_ram_instr = 3'b101;
    stall_push = 1'b1;
    offer("t3");
    chk("t3_c1_we", 32'(we), 0);
    chk("t3_c1_busy", 32'(busy), 1);
    step();
    chk("t3_c2_we", 32'(we), 0);
    chk("t3_c2_mm", 32'(main_mem_addr), 10);
    step();
    chk("t3_c3_we", 32'(we), 0);
    chk("t3_c3_cc", 32'(copy_count), 16);
    step();
    stall_push = 1'b0;
    #1;
    chk("t3_c4_we", 32'(we), 1);
    chk("t3_c4_cc", 32'(copy_count), 16);
    chk("t3_c4_mm", 32'(main_mem_addr), 10);
    chk("t3_c4_ram", 32'(ram_instr), 32'b101);
    step();
    chk("t3_c5_we", 32'(we), 1);
    chk("t3_c5_cc", 32'(copy_count), 4);
    chk("t3_c5_mm", 32'(main_mem_addr), 58);
    step();
    chk("t3_c6_ready", 32'(in_ready), 1);
    chk("t3_c6_we", 32'(we), 0);

    // PROG_END ignores its repeat count
    set_instr(T_END, 8'd200, 11'd9, 11'd1, 7'd0, 7'd0);
    offer("t4");
    chk("t4_c1_we", 32'(we), 1);
    chk("t4_c1_cc", 32'(copy_count), 1);
    chk("t4_c1_type", 32'(instr_type), 32'(T_END));
    step();
    chk("t4_c2_we", 32'(we), 0);
    chk("t4_c2_ready", 32'(in_ready), 1);

    // Repeat 0 behaves as 1
    set_instr(T_ARITH, 8'd0, 11'd4, 11'd1, 7'd0, 7'd0);
    offer("t5");
    chk("t5_c1_we", 32'(we), 1);
    chk("t5_c1_cc", 32'(copy_count), 1);
    step();
    chk("t5_c2_we", 32'(we), 0);
    chk("t5_c2_ready", 32'(in_ready), 1);

    // Exactly 16 copies: single full group
    set_instr(T_ARITH, 8'd16, 11'd0, 11'd1, 7'd0, 7'd0);
    offer("t6");
    chk("t6_c1_cc", 32'(copy_count), 16);
    chk("t6_c1_we", 32'(we), 1);
    step();
    chk("t6_c2_we", 32'(we), 0);

    // Maximum repeat 255: fifteen groups of 16 then 15
    set_instr(T_RAM, 8'd255, 11'd0, 11'd1, 7'd0, 7'd1);
    offer("t7");
    for (int g = 0; g < 16; g++) begin
      chk($sformatf("t7_g%0d_we", g), 32'(we), 1);
      chk($sformatf("t7_g%0d_cc", g), 32'(copy_count), (g < 15) ? 32'd16 : 32'd15);
      chk($sformatf("t7_g%0d_cache", g), 32'(cache_addr), 32'(g * 16));
      chk($sformatf("t7_g%0d_mm", g), 32'(main_mem_addr), 32'((g * 16) % 128));
      step();
    end
    chk("t7_end_we", 32'(we), 0);
    chk("t7_end_ready", 32'(in_ready), 1);

    // Reset during cycle 2 of a repeat-64 instruction
    set_instr(T_ARITH, 8'd64, 11'd7, 11'd1, 7'd5, 7'd1);
    in_arith_instr = 9'h0FF;
    offer("t8");
    chk("t8_c1_we", 32'(we), 1);
    step();
    chk("t8_c2_we", 32'(we), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t8_c3_we", 32'(we), 0);
    chk("t8_c3_ready", 32'(in_ready), 1);
    chk("t8_c3_busy", 32'(busy), 0);
    chk("t8_c3_cc", 32'(copy_count), 0);
    chk("t8_c3_cache", 32'(cache_addr), 0);
    chk("t8_c3_dca", 32'(d_cache_addr), 0);
    chk("t8_c3_mm", 32'(main_mem_addr), 0);
    chk("t8_c3_arith", 32'(arith_instr), 0);
    chk("t8_c3_type", 32'(instr_type), 0);
    step();
    chk("t8_c4_we", 32'(we), 0);

    // Back-to-back with in_valid held high
    set_instr(T_ARITH, 8'd17, 11'd0, 11'd1, 7'd0, 7'd0);
    in_valid = 1'b1;
    step();
    set_instr(T_LDST, 8'd5, 11'd500, 11'd2, 7'd1, 7'd1);
    chk("t9_c1_we", 32'(we), 1);
    chk("t9_c1_cc", 32'(copy_count), 16);
    chk("t9_c1_cache", 32'(cache_addr), 0);
    chk("t9_c1_ready", 32'(in_ready), 0);
    step();
    chk("t9_c2_we", 32'(we), 1);
    chk("t9_c2_cc", 32'(copy_count), 1);
    chk("t9_c2_cache", 32'(cache_addr), 16);
    chk("t9_c2_type", 32'(instr_type), 32'(T_ARITH));
    step();
    chk("t9_c3_we", 32'(we), 0);
    chk("t9_c3_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t9_c4_we", 32'(we), 1);
    chk("t9_c4_cc", 32'(copy_count), 5);
    chk("t9_c4_cache", 32'(cache_addr), 500);
    chk("t9_c4_type", 32'(instr_type), 32'(T_LDST));
    step();
    chk("t9_c5_we", 32'(we), 0);
    chk("t9_c5_ready", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
